// File: rtl/game_pkg.sv
// Shared types and constants for the red-light/green-light game.
// The round controller and the VGA scene logic both import this package.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INST  = 3'd1,
    ST_GAME  = 3'd2,
    ST_MODET = 3'd3,
    ST_KILL  = 3'd4,
    ST_DIE   = 3'd5,
    ST_WIN   = 3'd6,
    ST_END   = 3'd7
  } state_t;

  localparam int ROUND_MAX    = 15;
  localparam int SCENE_H_RES  = 640;
  localparam int SCENE_V_RES  = 480;
  localparam int SCENE_BORDER = 8;

  // Only these states run the one-second prescaler.
  function automatic logic is_timed(input state_t s);
    return (s == ST_GAME) || (s == ST_MODET) || (s == ST_KILL);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Game-second prescaler plus loadable seconds down-counter.
// A load (every state change) restarts the prescaler and sets the seconds value.
module sec_timer #(
  parameter int TICK_DIV = 25000000,
  parameter int VAL_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [VAL_W-1:0] i_value,
  input  logic             i_run,
  output logic             o_tick,
  output logic             o_expire,
  output logic [VAL_W-1:0] o_sec_left
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [VAL_W-1:0] r_sec;
  logic             r_tick;
  logic             w_boundary;

  assign w_boundary = i_run && (r_presc == PRESC_LAST);
  assign o_expire   = w_boundary && (r_sec == VAL_W'(1));
  assign o_tick     = r_tick;
  assign o_sec_left = r_sec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_tick  <= 1'b0;
    end else if (i_load) begin
      // The expiring tick still shows; a tick pre-empted by another transition does not.
      r_presc <= '0;
      r_sec   <= i_value;
      r_tick  <= o_expire;
    end else if (i_run) begin
      r_tick <= w_boundary;
      if (w_boundary) begin
        r_presc <= '0;
        r_sec   <= r_sec - VAL_W'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end else begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: game FSM, next-button edge detect, phase timing and servo window.
// Timing for GAME, MODET and KILL is delegated to a single shared sec_timer.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int MIN_SEC  = 2,
  parameter int KILL_SEC = 3,
  parameter int RAND_W   = 4
) (
  input  logic              i_clk_25,
  input  logic              i_rst,
  input  logic              i_next,
  input  logic [RAND_W-1:0] i_random,
  input  logic              i_finish_key,
  input  logic              i_detected,
  output logic [2:0]        o_state,
  output logic [RAND_W-1:0] o_sec_left,
  output logic              o_sec_tick,
  output logic              o_servo_fire,
  output logic [3:0]        o_round
);

  state_t            r_state;
  logic              r_next_d;
  logic              r_armed;
  logic              r_first;
  logic              r_servo;
  logic [3:0]        r_round;

  state_t            w_state_next;
  logic              w_next_rise;
  logic              w_load;
  logic              w_run;
  logic              w_expire;
  logic              w_tick;
  logic [RAND_W-1:0] w_value;
  logic [RAND_W-1:0] w_sec;
  logic [RAND_W-1:0] w_rand_clamped;

  // r_armed blocks a rise from a button that was already held through reset.
  assign w_next_rise    = i_next && !r_next_d && r_armed;
  assign w_rand_clamped = (i_random < RAND_W'(MIN_SEC)) ? RAND_W'(MIN_SEC) : i_random;
  assign w_run          = is_timed(r_state);
  assign w_load         = (w_state_next != r_state);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_next_rise) w_state_next = ST_INST;
      ST_INST:  if (w_next_rise) w_state_next = ST_GAME;
      ST_GAME: begin
        if (i_finish_key)  w_state_next = ST_WIN;
        else if (w_expire) w_state_next = ST_MODET;
      end
      ST_MODET: begin
        if (i_detected && !r_first) w_state_next = ST_KILL;
        else if (i_finish_key)      w_state_next = ST_WIN;
        else if (w_expire)          w_state_next = ST_GAME;
      end
      ST_KILL:  if (w_expire) w_state_next = ST_DIE;
      ST_DIE:   if (w_next_rise) w_state_next = ST_END;
      ST_WIN:   if (w_next_rise) w_state_next = ST_END;
      ST_END:   if (w_next_rise) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_value = '0;
    case (w_state_next)
      ST_GAME, ST_MODET: w_value = w_rand_clamped;
      ST_KILL:           w_value = RAND_W'(KILL_SEC);
      default:           w_value = '0;
    endcase
  end

  sec_timer #(
    .TICK_DIV (TICK_DIV),
    .VAL_W    (RAND_W)
  ) u_sec_timer (
    .i_clk      (i_clk_25),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_value    (w_value),
    .i_run      (w_run),
    .o_tick     (w_tick),
    .o_expire   (w_expire),
    .o_sec_left (w_sec)
  );

  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_next_d <= 1'b0;
      r_armed  <= !i_next;
      r_first  <= 1'b1;
      r_servo  <= 1'b0;
      r_round  <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_next_d <= i_next;
      r_armed  <= r_armed || !i_next;
      r_first  <= w_load;
      r_servo  <= (w_state_next == ST_KILL);
      if (w_load && (w_state_next == ST_GAME) && (r_round != 4'(ROUND_MAX))) begin
        r_round <= r_round + 4'd1;
      end else if (w_load && (w_state_next == ST_IDLE)) begin
        r_round <= 4'd0;
      end
    end
  end

  assign o_state      = r_state;
  assign o_sec_left   = w_sec;
  assign o_sec_tick   = w_tick;
  assign o_servo_fire = r_servo;
  assign o_round      = r_round;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with an elapsed-time reference model.
module tb_game_round_ctrl;

  localparam int TD   = 4;
  localparam int MINS = 2;
  localparam int KS   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nxt = 1'b0;
  logic [3:0] rnd = 4'd0;
  logic       fin = 1'b0;
  logic       det = 1'b0;
  logic [2:0] st;
  logic [3:0] sec;
  logic       tick;
  logic       servo;
  logic [3:0] rnd_cnt;

  int checks = 0;
  int failures = 0;

  // Model: state, loaded seconds and cycles elapsed since state entry.
  int m_state = 0, m_round = 0, m_n = 0, m_el = 0;
  bit m_tick = 0, m_prev = 0, m_armed = 1;

  game_round_ctrl #(.TICK_DIV(TD), .MIN_SEC(MINS), .KILL_SEC(KS), .RAND_W(4)) dut (
    .i_clk_25(clk), .i_rst(rst), .i_next(nxt), .i_random(rnd),
    .i_finish_key(fin), .i_detected(det), .o_state(st), .o_sec_left(sec),
    .o_sec_tick(tick), .o_servo_fire(servo), .o_round(rnd_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit timed(input int s);
    return (s == 2) || (s == 3) || (s == 4);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise, boundary, expire;
    int ns;
    if (rst) begin
      m_state = 0; m_round = 0; m_n = 0; m_el = 0; m_tick = 0;
      m_prev = 0; m_armed = !nxt;
      return;
    end
    rise = nxt && !m_prev && m_armed;
    m_armed = m_armed || !nxt;
    m_prev = nxt;
    boundary = timed(m_state) && (((m_el + 1) % TD) == 0);
    expire   = timed(m_state) && ((m_el + 1) == m_n * TD);
    ns = m_state;
    case (m_state)
      0: if (rise) ns = 1;
      1: if (rise) ns = 2;
      2: if (fin) ns = 6; else if (expire) ns = 3;
      3: if (det && m_el != 0) ns = 4; else if (fin) ns = 6; else if (expire) ns = 2;
      4: if (expire) ns = 5;
      5, 6: if (rise) ns = 7;
      default: if (rise) ns = 0;
    endcase
    m_tick = boundary && (ns == m_state || expire);
    if (ns != m_state) begin
      m_el = 0;
      if (ns == 2 || ns == 3) m_n = (rnd < MINS) ? MINS : int'(rnd);
      else if (ns == 4) m_n = KS;
      else m_n = 0;
      if (ns == 2 && m_round < 15) m_round++;
      if (ns == 0) m_round = 0;
    end else begin
      m_el++;
    end
    m_state = ns;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("state", int'(st), m_state);
    chk("sec_left", int'(sec), timed(m_state) ? (m_n - m_el / TD) : 0);
    chk("sec_tick", int'(tick), int'(m_tick));
    chk("servo_fire", int'(servo), (m_state == 4) ? 1 : 0);
    chk("round", int'(rnd_cnt), m_round);
  endtask

  task automatic pulse();
    nxt = 1'b1; cyc();
    nxt = 1'b0; cyc();
  endtask

  task automatic wait_state(input int s, output int n);
    n = 0;
    while (int'(st) != s && n < 100) begin
      cyc();
      n++;
    end
    if (int'(st) != s) chk("wait_timeout", int'(st), s);
  endtask

  initial begin
    int n, ticks, hi;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_state", int'(st), 0);
    chk("rst_servo", int'(servo), 0);
    $display("step reset: state=%0d round=%0d", st, rnd_cnt);

    // 1: held button gives one rise only
    nxt = 1'b1;
    repeat (10) cyc();
    chk("hold_state", int'(st), 1);
    chk("hold_round", int'(rnd_cnt), 0);
    nxt = 1'b0; cyc();
    rnd = 4'd5;
    nxt = 1'b1; cyc();
    chk("game_state", int'(st), 2);
    chk("game_round", int'(rnd_cnt), 1);
    chk("game_sec5", int'(sec), 5);
    $display("step inst->game: state=%0d sec=%0d round=%0d", st, sec, rnd_cnt);

    // 2: 20-cycle GAME, then MODET with random 0
    rnd = 4'd0;
    n = 0; ticks = 0;
    while (int'(st) == 2 && n < 100) begin
      cyc(); n++;
      if (tick) ticks++;
    end
    chk("game_len", n, 20);
    chk("game_ticks", ticks, 5);
    chk("modet_sec2", int'(sec), 2);
    nxt = 1'b0;
    wait_state(2, n);
    chk("modet_len", n, 8);
    chk("round2", int'(rnd_cnt), 2);
    $display("step game/modet: modet_len=%0d round=%0d", n, rnd_cnt);

    // 3: finish on the final tick wins
    repeat (7) cyc();
    fin = 1'b1; cyc(); fin = 1'b0;
    chk("finish_win", int'(st), 6);
    chk("win_sec0", int'(sec), 0);
    $display("step finish: state=%0d sec=%0d", st, sec);

    // 4: detection ignored in first MODET cycle, then beats finish
    pulse(); pulse();
    chk("end_idle_round", int'(rnd_cnt), 0);
    pulse();
    rnd = 4'd2; pulse();
    rnd = 4'd4;
    wait_state(3, n);
    det = 1'b1; cyc(); det = 1'b0;
    chk("det_ignored", int'(st), 3);
    cyc();
    det = 1'b1; fin = 1'b1; cyc(); det = 1'b0; fin = 1'b0;
    chk("kill_state", int'(st), 4);
    hi = servo ? 1 : 0; n = 0;
    while (int'(st) == 4 && n < 100) begin
      cyc(); n++;
      if (servo) hi++;
    end
    chk("servo_len", hi, 12);
    chk("die_state", int'(st), 5);
    chk("die_servo", int'(servo), 0);
    $display("step kill: servo_cycles=%0d state=%0d", hi, st);

    // 5: reset in the middle of KILL
    pulse(); pulse(); pulse();
    rnd = 4'd2; pulse();
    wait_state(3, n);
    cyc();
    det = 1'b1; cyc(); det = 1'b0;
    chk("kill2_state", int'(st), 4);
    repeat (4) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rkill_state", int'(st), 0);
    chk("rkill_servo", int'(servo), 0);
    chk("rkill_round", int'(rnd_cnt), 0);
    chk("rkill_sec", int'(sec), 0);
    $display("step reset-in-kill: state=%0d servo=%0d", st, servo);

    // 6: round saturation then full exit
    pulse(); pulse();
    for (int i = 0; i < 16; i++) begin
      wait_state(3, n);
      wait_state(2, n);
    end
    chk("round_sat", int'(rnd_cnt), 15);
    fin = 1'b1; cyc(); fin = 1'b0;
    chk("sat_win", int'(st), 6);
    pulse(); pulse();
    chk("exit_idle", int'(st), 0);
    chk("exit_round", int'(rnd_cnt), 0);
    pulse();
    chk("exit_inst", int'(st), 1);
    $display("step saturation: round cleared, state=%0d", st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
